// File: rtl/pipe_ctl_pkg.sv
// pipe_ctl shared constants: exception codes, fetch vector and FSM states.
// Optional feature macro: CPU_BREAK_HALT_EN (adds the debug HALT state).
package pipe_ctl_pkg;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_0100;

  localparam logic [4:0] CPU_EXC_ADEL = 5'd4;
  localparam logic [4:0] CPU_EXC_SYS  = 5'd8;
  localparam logic [4:0] CPU_EXC_BP   = 5'd9;
  localparam logic [4:0] CPU_EXC_OV   = 5'd12;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_HALT     = 3'd4
  } pipe_state_e;

  // A faulting delay-slot instruction restarts at its branch.
  function automatic logic [31:0] epc_of(
    input logic [31:0] pc,
    input logic        bd
  );
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/pipe_ctl_if.sv
// Fetch redirect handshake between pipe_ctl (master) and fetch (slave).
// Target and valid are held stable until fetch acknowledges.
interface pipe_ctl_if;
  logic [31:0] o_new_pc;
  logic        o_new_pc_valid;
  logic        i_fetch_ack;

  modport master (
    output o_new_pc,
    output o_new_pc_valid,
    input  i_fetch_ack
  );

  modport slave (
    input  o_new_pc,
    input  o_new_pc_valid,
    output i_fetch_ack
  );
endinterface

// File: rtl/pipe_ctl_exc_prio.sv
// Execute-stage event priority encoder:
// addr_error > overflow > syscall > break > eret.
module pipe_ctl_exc_prio
  import pipe_ctl_pkg::*;
(
  input  logic       i_addr_error,
  input  logic       i_overfl_error,
  input  logic       i_syscall_trap,
  input  logic       i_break_trap,
  input  logic       i_eret,
  output logic       o_valid,
  output logic [4:0] o_code,
  output logic       o_is_eret
);

  always_comb begin
    o_valid   = 1'b1;
    o_code    = 5'd0;
    o_is_eret = 1'b0;
    priority case (1'b1)
      i_addr_error:   o_code = CPU_EXC_ADEL;
      i_overfl_error: o_code = CPU_EXC_OV;
      i_syscall_trap: o_code = CPU_EXC_SYS;
      i_break_trap:   o_code = CPU_EXC_BP;
      i_eret:         o_is_eret = 1'b1;
      default:        o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_ctl.sv
// Pipeline stall generation plus exception-entry / ERET sequencing.
// Optional macro CPU_BREAK_HALT_EN turns break into a debug HALT.
module pipe_ctl
  import pipe_ctl_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_fetch_busy,
  input  logic        i_mem_busy,
  input  logic        i_imuldiv_busy,
  input  logic        i_imuldiv_use,
  input  logic        i_overfl_error,
  input  logic        i_addr_error,
  input  logic        i_syscall_trap,
  input  logic        i_break_trap,
  input  logic        i_eret,
  input  logic [31:0] i_exec_pc,
  input  logic        i_exec_bd,
  input  logic [31:0] i_epc,
  pipe_ctl_if.master  redir,
  output logic        o_fetch_stall,
  output logic        o_exec_stall,
  output logic        o_mem_stall,
  output logic        o_flush,
  output logic        o_epc_wr,
  output logic [31:0] o_epc,
  output logic [4:0]  o_cause_exc,
  output logic        o_cause_bd,
`ifdef CPU_BREAK_HALT_EN
  input  logic        i_dbg_resume,
  output logic        o_halted,
`endif
  output logic        o_exc_mode
);

  pipe_state_e state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  code_q, code_d;
  logic        bd_q, bd_d;
  logic [31:0] tgt_q, tgt_d;
  logic        excm_q, excm_d;
  logic        eret_q, eret_d;
  logic        halt_q, halt_d;

  logic       ev_valid;
  logic [4:0] ev_code;
  logic       ev_eret;
  logic       halt_evt;
  logic       take;

  pipe_ctl_exc_prio u_prio (
    .i_addr_error   (i_addr_error),
    .i_overfl_error (i_overfl_error),
    .i_syscall_trap (i_syscall_trap),
    .i_break_trap   (i_break_trap),
    .i_eret         (i_eret),
    .o_valid        (ev_valid),
    .o_code         (ev_code),
    .o_is_eret      (ev_eret)
  );

`ifdef CPU_BREAK_HALT_EN
  assign halt_evt = ev_valid & ~ev_eret & (ev_code == CPU_EXC_BP);
`else
  assign halt_evt = 1'b0;
`endif

  // A busy memory stage does not block capture; DRAIN waits it out.
  assign take = (state_q == ST_RUN) & ev_valid & ~i_fetch_busy
              & ~(i_imuldiv_busy & i_imuldiv_use);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_RUN;
      epc_q   <= '0;
      code_q  <= '0;
      bd_q    <= 1'b0;
      tgt_q   <= '0;
      excm_q  <= 1'b0;
      eret_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      code_q  <= code_d;
      bd_q    <= bd_d;
      tgt_q   <= tgt_d;
      excm_q  <= excm_d;
      eret_q  <= eret_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (take) begin
          if (i_mem_busy) state_d = ST_DRAIN;
          else if (halt_evt) state_d = ST_HALT;
          else state_d = ST_FLUSH;
        end
      end
      ST_DRAIN: begin
        if (!i_mem_busy) state_d = halt_q ? ST_HALT : ST_FLUSH;
      end
      ST_FLUSH:    state_d = ST_REDIRECT;
      ST_REDIRECT: begin
        if (redir.i_fetch_ack) state_d = ST_RUN;
      end
`ifdef CPU_BREAK_HALT_EN
      ST_HALT: begin
        if (i_dbg_resume) state_d = ST_RUN;
      end
`endif
      default:     state_d = ST_RUN;
    endcase
  end

  always_comb begin
    epc_d  = epc_q;
    code_d = code_q;
    bd_d   = bd_q;
    tgt_d  = tgt_q;
    excm_d = excm_q;
    eret_d = eret_q;
    halt_d = halt_q;
    if (take) begin
      halt_d = halt_evt;
      if (!halt_evt) begin
        eret_d = ev_eret;
        tgt_d  = ev_eret ? i_epc : EXC_VECTOR;
        if (!ev_eret) begin
          epc_d  = epc_of(i_exec_pc, i_exec_bd);
          code_d = ev_code;
          bd_d   = i_exec_bd;
        end
      end
    end
    if (state_q == ST_FLUSH) excm_d = ~eret_q;
  end

  logic in_run;
  logic in_halt;

  always_comb begin
    in_run               = (state_q == ST_RUN);
    in_halt              = (state_q == ST_HALT);
    o_fetch_stall        = in_run ? i_fetch_busy : 1'b1;
    o_exec_stall         = in_run ? (i_imuldiv_busy & i_imuldiv_use) : 1'b1;
    o_mem_stall          = i_mem_busy | in_halt;
    o_flush              = (state_q == ST_FLUSH);
    o_epc_wr             = (state_q == ST_FLUSH) & ~eret_q;
    redir.o_new_pc_valid = (state_q == ST_REDIRECT);
    redir.o_new_pc       = tgt_q;
    o_epc                = epc_q;
    o_cause_exc          = code_q;
    o_cause_bd           = bd_q;
    o_exc_mode           = excm_q;
`ifdef CPU_BREAK_HALT_EN
    o_halted             = in_halt;
`endif
  end

endmodule

// File: tb/tb_pipe_ctl.sv
// Self-checking bench for pipe_ctl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_pipe_ctl;

  logic        clk;
  logic        nrst;
  logic        i_fetch_busy, i_mem_busy;
  logic        i_imuldiv_busy, i_imuldiv_use;
  logic        i_overfl_error, i_addr_error;
  logic        i_syscall_trap, i_break_trap, i_eret;
  logic [31:0] i_exec_pc, i_epc;
  logic        i_exec_bd;
  logic        o_fetch_stall, o_exec_stall, o_mem_stall;
  logic        o_flush, o_epc_wr, o_cause_bd, o_exc_mode;
  logic [31:0] o_epc;
  logic [4:0]  o_cause_exc;
`ifdef CPU_BREAK_HALT_EN
  logic        i_dbg_resume;
  logic        o_halted;
`endif

  pipe_ctl_if redir_if ();

  pipe_ctl dut (
    .clk            (clk),
    .nrst           (nrst),
    .i_fetch_busy   (i_fetch_busy),
    .i_mem_busy     (i_mem_busy),
    .i_imuldiv_busy (i_imuldiv_busy),
    .i_imuldiv_use  (i_imuldiv_use),
    .i_overfl_error (i_overfl_error),
    .i_addr_error   (i_addr_error),
    .i_syscall_trap (i_syscall_trap),
    .i_break_trap   (i_break_trap),
    .i_eret         (i_eret),
    .i_exec_pc      (i_exec_pc),
    .i_exec_bd      (i_exec_bd),
    .i_epc          (i_epc),
    .redir          (redir_if),
    .o_fetch_stall  (o_fetch_stall),
    .o_exec_stall   (o_exec_stall),
    .o_mem_stall    (o_mem_stall),
    .o_flush        (o_flush),
    .o_epc_wr       (o_epc_wr),
    .o_epc          (o_epc),
    .o_cause_exc    (o_cause_exc),
    .o_cause_bd     (o_cause_bd),
`ifdef CPU_BREAK_HALT_EN
    .i_dbg_resume   (i_dbg_resume),
    .o_halted       (o_halted),
`endif
    .o_exc_mode     (o_exc_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: stage 0 running, 1 waiting for memory, 2 flush, 3 redirect.
  int          m_stage;
  logic [31:0] m_epc, m_tgt;
  logic [4:0]  m_code;
  logic        m_bd, m_excm, m_eret;

  task automatic model_reset();
    m_stage = 0; m_epc = 0; m_tgt = 0; m_code = 0;
    m_bd = 0; m_excm = 0; m_eret = 0;
  endtask

  task automatic model_adv();
    bit any_ev;
    if (!nrst) begin
      model_reset();
      return;
    end
    any_ev = i_addr_error | i_overfl_error | i_syscall_trap
           | i_break_trap | i_eret;
    case (m_stage)
      0: if (any_ev && !i_fetch_busy && !(i_imuldiv_busy && i_imuldiv_use)) begin
        m_eret = !(i_addr_error | i_overfl_error | i_syscall_trap | i_break_trap);
        if (m_eret) m_tgt = i_epc;
        else begin
          m_tgt = 32'h100;
          m_epc = i_exec_bd ? i_exec_pc - 4 : i_exec_pc;
          m_bd  = i_exec_bd;
          if (i_addr_error) m_code = 4;
          else if (i_overfl_error) m_code = 12;
          else if (i_syscall_trap) m_code = 8;
          else m_code = 9;
        end
        m_stage = i_mem_busy ? 1 : 2;
      end
      1: if (!i_mem_busy) m_stage = 2;
      2: begin m_excm = !m_eret; m_stage = 3; end
      default: if (redir_if.i_fetch_ack) m_stage = 0;
    endcase
  endtask

  task automatic cmp_model();
    bit seq;
    seq = (m_stage != 0);
    chk("fetch_stall", 32'(o_fetch_stall), 32'(seq ? 1'b1 : i_fetch_busy));
    chk("exec_stall", 32'(o_exec_stall),
        32'(seq ? 1'b1 : (i_imuldiv_busy & i_imuldiv_use)));
    chk("mem_stall", 32'(o_mem_stall), 32'(i_mem_busy));
    chk("flush", 32'(o_flush), 32'(m_stage == 2));
    chk("epc_wr", 32'(o_epc_wr), 32'(m_stage == 2 && !m_eret));
    chk("new_pc_valid", 32'(redir_if.o_new_pc_valid), 32'(m_stage == 3));
    chk("new_pc", redir_if.o_new_pc, m_tgt);
    chk("epc", o_epc, m_epc);
    chk("cause_exc", 32'(o_cause_exc), 32'(m_code));
    chk("cause_bd", 32'(o_cause_bd), 32'(m_bd));
    chk("exc_mode", 32'(o_exc_mode), 32'(m_excm));
  endtask

  task automatic cyc();
    @(negedge clk);
    cmp_model();
    @(posedge clk);
    model_adv();
    #1;
  endtask

  task automatic clr_in();
    i_fetch_busy = 0; i_mem_busy = 0; i_imuldiv_busy = 0;
    i_imuldiv_use = 0; i_overfl_error = 0; i_addr_error = 0;
    i_syscall_trap = 0; i_break_trap = 0; i_eret = 0;
    i_exec_pc = 0; i_exec_bd = 0; i_epc = 0;
    redir_if.i_fetch_ack = 0;
`ifdef CPU_BREAK_HALT_EN
    i_dbg_resume = 0;
`endif
  endtask

  int cnt;

  initial begin
    clr_in();
    nrst = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(redir_if.o_new_pc_valid), 0);
    chk("rst_new_pc", redir_if.o_new_pc, 0);
    chk("rst_epc", o_epc, 0);
    chk("rst_exc_mode", 32'(o_exc_mode), 0);
    chk("rst_stalls", {o_fetch_stall, o_exec_stall, o_mem_stall, o_flush}, 0);
    nrst = 1;
    cyc();

    // Overflow at 0x200, memory idle
    i_overfl_error = 1; i_exec_pc = 32'h200;
    cyc();
    i_overfl_error = 0;
    chk("ov_flush", 32'(o_flush), 1);
    chk("ov_epc_wr", 32'(o_epc_wr), 1);
    chk("ov_epc", o_epc, 32'h200);
    chk("ov_code", 32'(o_cause_exc), 12);
    cyc();
    chk("ov_valid", 32'(redir_if.o_new_pc_valid), 1);
    chk("ov_new_pc", redir_if.o_new_pc, 32'h100);
    chk("ov_exc_mode", 32'(o_exc_mode), 1);
    cyc();
    chk("ov_valid_hold", 32'(redir_if.o_new_pc_valid), 1);
    redir_if.i_fetch_ack = 1;
    cyc();
    redir_if.i_fetch_ack = 0;
    chk("ov_back_run", {redir_if.o_new_pc_valid, o_fetch_stall}, 0);

    // Syscall in a delay slot at 0x304 with memory busy for 3 cycles
    i_syscall_trap = 1; i_exec_pc = 32'h304; i_exec_bd = 1; i_mem_busy = 1;
    cyc();
    i_syscall_trap = 0; i_exec_bd = 0;
    cyc();
    cyc();
    i_mem_busy = 0;
    chk("sys_drain", {o_flush, o_fetch_stall, o_exec_stall}, 32'b011);
    cyc();
    chk("sys_flush", 32'(o_flush), 1);
    chk("sys_epc", o_epc, 32'h300);
    chk("sys_bd", 32'(o_cause_bd), 1);
    chk("sys_code", 32'(o_cause_exc), 8);
    redir_if.i_fetch_ack = 1;
    cyc();
    cyc();
    redir_if.i_fetch_ack = 0;

    // addr_error and overflow together
    i_addr_error = 1; i_overfl_error = 1; i_exec_pc = 32'h400;
    redir_if.i_fetch_ack = 1;
    cyc();
    i_addr_error = 0; i_overfl_error = 0;
    cnt = 32'(o_epc_wr);
    repeat (5) begin cyc(); cnt += 32'(o_epc_wr); end
    chk("prio_wr_pulses", cnt, 1);
    chk("prio_code", 32'(o_cause_exc), 4);
    redir_if.i_fetch_ack = 0;

    // Overflow held through a mul/div stall is taken once
    i_overfl_error = 1; i_exec_pc = 32'h500;
    i_imuldiv_busy = 1; i_imuldiv_use = 1;
    cnt = 0;
    repeat (4) begin cyc(); cnt += 32'(o_flush); end
    chk("stall_no_take", cnt, 0);
    i_imuldiv_busy = 0;
    cyc();
    i_overfl_error = 0; redir_if.i_fetch_ack = 1;
    cnt = 32'(o_flush);
    repeat (5) begin cyc(); cnt += 32'(o_flush); end
    chk("stall_one_seq", cnt, 1);
    redir_if.i_fetch_ack = 0; i_imuldiv_use = 0;

    // ERET to 0x1234
    i_eret = 1; i_epc = 32'h1234;
    cyc();
    i_eret = 0;
    chk("eret_flush", 32'(o_flush), 1);
    chk("eret_no_wr", 32'(o_epc_wr), 0);
    cyc();
    chk("eret_new_pc", redir_if.o_new_pc, 32'h1234);
    chk("eret_valid", 32'(redir_if.o_new_pc_valid), 1);
    chk("eret_exc_mode", 32'(o_exc_mode), 0);
    redir_if.i_fetch_ack = 1;
    cyc();
    redir_if.i_fetch_ack = 0;

    // Reset while redirect is pending
    i_overfl_error = 1; i_exec_pc = 32'h600;
    cyc();
    i_overfl_error = 0;
    cyc();
    chk("pre_rst_valid", 32'(redir_if.o_new_pc_valid), 1);
    nrst = 0;
    #1;
    chk("mid_rst_valid", 32'(redir_if.o_new_pc_valid), 0);
    chk("mid_rst_new_pc", redir_if.o_new_pc, 0);
    chk("mid_rst_epc", o_epc, 0);
    chk("mid_rst_misc", {o_cause_exc, o_cause_bd, o_exc_mode, o_fetch_stall}, 0);
    model_reset();
    cyc();
    nrst = 1;
    cyc();
    chk("post_rst_run", {redir_if.o_new_pc_valid, o_fetch_stall}, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      i_fetch_busy   = ($urandom_range(0, 3) == 0);
      i_mem_busy     = ($urandom_range(0, 2) == 0);
      i_imuldiv_busy = ($urandom_range(0, 2) == 0);
      i_imuldiv_use  = $urandom_range(0, 1) == 1;
      i_addr_error   = ($urandom_range(0, 15) == 0);
      i_overfl_error = ($urandom_range(0, 15) == 0);
      i_syscall_trap = ($urandom_range(0, 15) == 0);
      i_break_trap   = ($urandom_range(0, 15) == 0);
      i_eret         = ($urandom_range(0, 11) == 0);
      i_exec_pc      = $urandom & 32'hFFFF_FFFC;
      i_exec_bd      = $urandom_range(0, 1) == 1;
      i_epc          = $urandom & 32'hFFFF_FFFC;
      redir_if.i_fetch_ack = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
